ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. It sends one command byte (e.g. 0xFF reset, 0xF4 enable reporting) over the open-drain ps2_clk/ps2_data pins that the VGAController's PS/2 receiver listens on. It runs on the 50 MHz system clock and drives the lines only as active-low output enables; the top level ties each pin to `oe ? 1'b0 : 1'bz`. The busy output lets the receiver ignore line activity during a host frame.

Parameters:
INHIBIT_CYCLES, 6000, cycles the clock line is held low before the start bit (120 µs at 50 MHz).
TIMEOUT_CYCLES, 750000, maximum cycles allowed between consecutive device clock falling edges, and before the lines go idle (15 ms).
FILTER_LEN, 8, consecutive equal synchronized samples required to accept a new level on either line.

Ports:
clock  in  1  system clock (50 MHz)
reset  in  1  synchronous, active-high
tx_data  in  8  command byte
tx_valid  in  1  request; accepted on a cycle where tx_valid & tx_ready
tx_ready  out  1  high only in IDLE
ps2_clk_in  in  1  raw pin level
ps2_data_in  in  1  raw pin level
ps2_clk_oe  out  1  1 = pull clock low
ps2_data_oe  out  1  1 = pull data low
busy  out  1  high in every state except IDLE
done  out  1  1-cycle pulse: frame acked and lines idle
error  out  1  1-cycle pulse: no ack, or timeout

Behaviour:
- Reset values: ps2_clk_oe=0, ps2_data_oe=0, done=0, error=0, busy=0, tx_ready=1; state=IDLE; counters=0. Reset mid-frame releases both lines on the next edge with no done/error pulse.
- Input conditioning:
  - 2-flop synchronizer, then a FILTER_LEN-sample filter per line. The filtered clock and data reset to 1.
  - fall = filtered clock 1→0. Data sampling uses the filtered data.
- All outputs are registered.
- IDLE:
  - On accept, latch shift reg = {1'b1 stop, ~^tx_data odd parity, tx_data}.
  - Set bitcnt=0 and go INHIBIT; ps2_clk_oe=1 from the next cycle.
  - tx_valid while busy is ignored, with no queueing.
- INHIBIT:
  - ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles.
  - In the last of these cycles, ps2_data_oe=1 (start bit 0).
  - Then go REQ: clk_oe=0, data_oe stays 1, timeout counter cleared.
- REQ/SHIFT:
  - On each fall, present the next shift-reg LSB: data_oe = ~bit. Shift right, bitcnt++.
  - Falls 1–8 present data bits LSB-first, fall 9 presents parity, fall 10 presents stop (data_oe=0, released).
  - Go ACK after fall 10.
- ACK:
  - On fall 11, sample filtered data. If 0, go WAIT_IDLE.
  - If 1, pulse error and go IDLE.
- WAIT_IDLE: when filtered clock=1 and data=1, pulse done and go IDLE.
- Timeout:
  - In REQ, SHIFT, ACK and WAIT_IDLE the counter increments each cycle and clears on every fall.
  - On reaching TIMEOUT_CYCLES, release both lines the next cycle, pulse error and go IDLE.
  - done and error are never asserted in the same cycle.
- Fall coinciding with the timeout terminal count: the fall wins and the counter clears.
- Counters are sized with $clog2 of their parameter; there is no wrap-around beyond the terminal count.

Decomposition:
- ps2_pkg:
  - state encoding: IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE
  - frame constants: DATA_BITS=8, FRAME_FALLS=11
  - command codes: CMD_RESET=8'hFF, CMD_ENABLE=8'hF4, ACK_BYTE=8'hFA
- Sub-module ps2_line_filter (sync + FILTER_LEN filter + fall detect). Instantiated twice here and reusable by the receiver.

Test Plan (bench params: INHIBIT_CYCLES=20, TIMEOUT_CYCLES=200, FILTER_LEN=2; device model clocks at 40-cycle period):
- tx_data=0xF4 with an acking device -> clk_oe high exactly 20 cycles; device samples 0,0,0,1,0,1,1,1,1, parity 0, stop 1; done pulses once; error=0.
- tx_data=0xFF -> parity bit sampled as 1; done pulses.
- Device never pulls data low on fall 11 -> error pulses 1 cycle after fall 11; no done; both oe=0; tx_ready=1.
- Device never clocks after the inhibit -> error after 200 cycles; lines released; state IDLE.
- reset asserted after fall 4 -> next cycle clk_oe=0, data_oe=0, busy=0, no pulses; a fresh 0xF4 then completes normally.
- tx_valid=1 with 0x00 held during the 0xF4 frame -> not accepted until IDLE; exactly two frames sent (0xF4 then 0x00, parity 1).

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 state encoding, frame constants, command codes and frame builder.
package ps2_pkg;
    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE} ps2_state_t;

    localparam int DATA_BITS   = 8;
    localparam int FRAME_FALLS = 11;

    localparam logic [7:0] CMD_RESET  = 8'hFF;
    localparam logic [7:0] CMD_ENABLE = 8'hF4;
    localparam logic [7:0] ACK_BYTE   = 8'hFA;

    // Bits shifted out after the start bit, LSB first: data, odd parity, stop.
    function automatic logic [DATA_BITS+1:0] host_frame(input logic [DATA_BITS-1:0] d);
        return {1'b1, ~^d, d};
    endfunction
endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: 2-flop synchronizer, FILTER_LEN-sample level filter and falling-edge pulse.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_raw,
    output logic o_level,
    output logic o_fall
);
    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_fall;
    logic          w_flip;

    // Flip on the FILTER_LEN-th consecutive sample that disagrees with the held level.
    assign w_flip = (r_sync[1] != r_level) && (r_cnt == CW'(FILTER_LEN - 1));

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_sync  <= 2'b11;
            r_cnt   <= '0;
            r_level <= 1'b1;
            r_fall  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_raw};
            r_cnt   <= (r_sync[1] == r_level || w_flip) ? '0 : r_cnt + CW'(1);
            r_level <= w_flip ? r_sync[1] : r_level;
            r_fall  <= w_flip && r_level;
        end
    end

    assign o_level = r_level;
    assign o_fall  = r_fall;
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter driving open-drain
// clock/data through active-high pull-low enables.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_valid,
    output logic       o_tx_ready,
    input  logic       i_ps2_clk_in,
    input  logic       i_ps2_data_in,
    output logic       o_ps2_clk_oe,
    output logic       o_ps2_data_oe,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_error
);
    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int BW      = $clog2(FRAME_FALLS + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [BW-1:0] STOP_IDX = BW'(FRAME_FALLS - 2);

    ps2_state_t           r_state, w_state;
    logic [CW-1:0]        r_cnt, w_cnt;
    logic [BW-1:0]        r_bitcnt, w_bitcnt;
    logic [DATA_BITS+1:0] r_shift, w_shift;
    logic                 r_clk_oe, r_data_oe, w_data_oe;
    logic                 r_done, w_done, r_error, w_error;
    logic                 r_busy, r_ready;
    logic                 w_clk_lvl, w_clk_fall, w_data_lvl, w_data_fall_unused;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .i_clock(i_clock), .i_reset(i_reset), .i_raw(i_ps2_clk_in),
        .o_level(w_clk_lvl), .o_fall(w_clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .i_clock(i_clock), .i_reset(i_reset), .i_raw(i_ps2_data_in),
        .o_level(w_data_lvl), .o_fall(w_data_fall_unused)
    );

    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_bitcnt  = r_bitcnt;
        w_shift   = r_shift;
        w_data_oe = r_data_oe;
        w_done    = 1'b0;
        w_error   = 1'b0;
        case (r_state)
            IDLE: if (i_tx_valid) begin
                w_state   = INHIBIT;
                w_cnt     = '0;
                w_bitcnt  = '0;
                w_shift   = host_frame(i_tx_data);
                w_data_oe = (INH_LAST == '0);
            end
            INHIBIT: if (r_cnt == INH_LAST) begin
                w_state = REQ;
                w_cnt   = '0;
            end else begin
                w_cnt     = r_cnt + CW'(1);
                w_data_oe = (w_cnt == INH_LAST);
            end
            default: begin
                // A device clock fall always beats the timeout terminal count.
                w_cnt = w_clk_fall ? '0 : r_cnt + CW'(1);
                if (w_clk_fall && (r_state == REQ || r_state == SHIFT)) begin
                    w_data_oe = ~r_shift[0];
                    w_shift   = r_shift >> 1;
                    w_bitcnt  = r_bitcnt + BW'(1);
                    w_state   = (r_bitcnt == STOP_IDX) ? ACK : SHIFT;
                end else if (w_clk_fall && r_state == ACK) begin
                    w_state = w_data_lvl ? IDLE : WAIT_IDLE;
                    w_error = w_data_lvl;
                end else if (r_state == WAIT_IDLE && w_clk_lvl && w_data_lvl) begin
                    w_state = IDLE;
                    w_done  = 1'b1;
                end else if (!w_clk_fall && r_cnt == TO_LAST) begin
                    w_state = IDLE;
                    w_error = 1'b1;
                end
            end
        endcase
        if (w_state == IDLE) begin
            w_cnt     = '0;
            w_data_oe = 1'b0;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bitcnt  <= '0;
            r_shift   <= '0;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_busy    <= 1'b0;
            r_ready   <= 1'b1;
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_bitcnt  <= w_bitcnt;
            r_shift   <= w_shift;
            r_clk_oe  <= (w_state == INHIBIT);
            r_data_oe <= w_data_oe;
            r_done    <= w_done;
            r_error   <= w_error;
            r_busy    <= (w_state != IDLE);
            r_ready   <= (w_state == IDLE);
        end
    end

    assign o_tx_ready    = r_ready;
    assign o_ps2_clk_oe  = r_clk_oe;
    assign o_ps2_data_oe = r_data_oe;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_error       = r_error;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: table-driven bench with a behavioural PS/2 device on the open-drain lines.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    typedef struct {
        logic [7:0]  data;
        logic        ack;
        logic [10:0] frame;
        int          dones;
        int          errs;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_valid = 1'b0;
    logic        tx_ready, clk_oe, data_oe, busy, done, error;
    logic        clk_pin, data_pin;
    logic        dev_clk_low = 1'b0, dev_data_low = 1'b0, dev_ack = 1'b1, dev_busy = 1'b0;
    int          dev_pulses = 11;
    int          done_cnt = 0, err_cnt = 0, both_cnt = 0;
    int          checks = 0, passes = 0;
    logic [10:0] frames[$];
    int          inh_len[$];
    int          inh_data[$];
    vec_t        vecs[5];

    assign clk_pin  = !(clk_oe || dev_clk_low);
    assign data_pin = !(data_oe || dev_data_low);

    always #5 clk = ~clk;

    ps2_host_tx #(.INHIBIT_CYCLES(20), .TIMEOUT_CYCLES(200), .FILTER_LEN(2)) dut (
        .i_clock(clk), .i_reset(rst), .i_tx_data(tx_data), .i_tx_valid(tx_valid),
        .o_tx_ready(tx_ready), .i_ps2_clk_in(clk_pin), .i_ps2_data_in(data_pin),
        .o_ps2_clk_oe(clk_oe), .o_ps2_data_oe(data_oe), .o_busy(busy),
        .o_done(done), .o_error(error)
    );

    always @(negedge clk) begin
        done_cnt <= done_cnt + int'(done);
        err_cnt  <= err_cnt + int'(error);
        both_cnt <= both_cnt + int'(done && error);
    end

    // Device: measures the inhibit, then clocks 40-cycle pulses and samples data on the rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (clk_oe) begin
                int n, nd;
                logic [10:0] f;
                n = 0;
                nd = 0;
                f = '0;
                dev_busy = 1'b1;
                while (clk_oe) begin
                    n++;
                    nd += int'(data_oe);
                    @(negedge clk);
                end
                f[0] = data_pin;
                for (int k = 0; k < dev_pulses; k++) begin
                    if (k == 10) dev_data_low = dev_ack;
                    repeat (10) @(negedge clk);
                    dev_clk_low = 1'b1;
                    repeat (20) @(negedge clk);
                    if (k < 10) f[k+1] = data_pin;
                    dev_clk_low = 1'b0;
                    repeat (10) @(negedge clk);
                end
                dev_data_low = 1'b0;
                if (dev_pulses == 11) begin
                    frames.push_back(f);
                    inh_len.push_back(n);
                    inh_data.push_back(nd);
                end
                dev_busy = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic send(input logic [7:0] d);
        tx_data = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int d0, e0, nf, t;
        d0 = done_cnt;
        e0 = err_cnt;
        nf = frames.size();
        dev_ack = v.ack;
        dev_pulses = 11;
        send(v.data);
        t = 0;
        while (t < 3000 && !(frames.size() > nf && !dev_busy && done_cnt + err_cnt > d0 + e0)) begin
            @(negedge clk);
            t++;
        end
        check({tag, " completes"}, 32'(t < 3000), 1);
        repeat (10) @(negedge clk);
        check({tag, " frame count"}, frames.size(), nf + 1);
        if (frames.size() > nf) begin
            check({tag, " frame bits"}, 32'(frames[nf]), 32'(v.frame));
            check({tag, " inhibit cycles"}, inh_len[nf], 20);
            check({tag, " start-bit cycles"}, inh_data[nf], 1);
        end
        check({tag, " done pulses"}, done_cnt - d0, v.dones);
        check({tag, " error pulses"}, err_cnt - e0, v.errs);
        check({tag, " ready"}, tx_ready, 1);
        check({tag, " busy"}, busy, 0);
        check({tag, " clk_oe"}, clk_oe, 0);
        check({tag, " data_oe"}, data_oe, 0);
    endtask

    initial begin
        int d0, e0, nf, t, n;
        vecs[0] = '{CMD_ENABLE, 1'b1, 11'h5E8, 1, 0};
        vecs[1] = '{CMD_RESET,  1'b1, 11'h7FE, 1, 0};
        vecs[2] = '{ACK_BYTE,   1'b1, 11'h7F4, 1, 0};
        vecs[3] = '{8'h01,      1'b1, 11'h402, 1, 0};
        vecs[4] = '{CMD_ENABLE, 1'b0, 11'h5E8, 0, 1};

        repeat (3) @(negedge clk);
        check("reset ready", tx_ready, 1);
        check("reset busy", busy, 0);
        check("reset clk_oe", clk_oe, 0);
        check("reset data_oe", data_oe, 0);
        check("reset done", done, 0);
        check("reset error", error, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Device never clocks after the inhibit.
        dev_pulses = 0;
        d0 = done_cnt;
        e0 = err_cnt;
        send(8'h55);
        t = 0;
        while (t < 100 && clk_oe) begin
            @(negedge clk);
            t++;
        end
        n = 0;
        while (n < 400 && !error) begin
            @(negedge clk);
            n++;
        end
        check("timeout cycles", n, 200);
        check("timeout clk_oe", clk_oe, 0);
        check("timeout data_oe", data_oe, 0);
        check("timeout ready", tx_ready, 1);
        repeat (10) @(negedge clk);
        check("timeout error pulses", err_cnt - e0, 1);
        check("timeout done pulses", done_cnt - d0, 0);

        // Reset after the fourth device clock fall.
        dev_pulses = 4;
        dev_ack = 1'b1;
        d0 = done_cnt;
        e0 = err_cnt;
        send(CMD_ENABLE);
        t = 0;
        while (t < 2000 && !dev_busy) begin
            @(negedge clk);
            t++;
        end
        while (t < 2000 && dev_busy) begin
            @(negedge clk);
            t++;
        end
        check("midframe reached", 32'(t < 2000), 1);
        check("midframe data_oe", data_oe, 1);
        check("midframe busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("midreset clk_oe", clk_oe, 0);
        check("midreset data_oe", data_oe, 0);
        check("midreset busy", busy, 0);
        check("midreset ready", tx_ready, 1);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("midreset no pulses", (done_cnt - d0) + (err_cnt - e0), 0);
        run_vec(vecs[0], "post-reset");

        // tx_valid held with a second byte while the first frame is in flight.
        dev_pulses = 11;
        dev_ack = 1'b1;
        nf = frames.size();
        d0 = done_cnt;
        tx_data = CMD_ENABLE;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_data = 8'h00;
        check("queue busy", busy, 1);
        t = 0;
        while (t < 3000 && !done) begin
            @(negedge clk);
            t++;
        end
        while (t < 3000 && !busy) begin
            @(negedge clk);
            t++;
        end
        tx_valid = 1'b0;
        while (t < 6000 && !(frames.size() >= nf + 2 && !dev_busy && done_cnt >= d0 + 2)) begin
            @(negedge clk);
            t++;
        end
        check("queue completes", 32'(t < 6000), 1);
        repeat (60) @(negedge clk);
        check("queue frame count", frames.size(), nf + 2);
        if (frames.size() >= nf + 2) begin
            check("queue first frame", 32'(frames[nf]), 32'h5E8);
            check("queue second frame", 32'(frames[nf+1]), 32'h600);
        end
        check("queue done pulses", done_cnt - d0, 2);
        check("queue idle", busy, 0);
        check("done/error overlap", both_cnt, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
